// File: rtl/mem_access.sv
// Data-memory access stage: issues word-aligned bus requests for loads/stores,
// right-justifies load data, and passes non-memory ops through one register stage.
module mem_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [3:0]  op_type,
  input  logic [4:0]  op_spec,
  input  logic [31:0] addr,
  input  logic [31:0] st_dat,
  input  logic [4:0]  rd_ind,
  input  logic [31:0] rd_dat,
  output logic        stall,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [31:0] req_addr,
  output logic [3:0]  req_be,
  output logic [31:0] req_wdat,
  input  logic        resp_valid,
  input  logic [31:0] resp_rdat,
  output logic        out_valid,
  output logic [3:0]  op_type_out,
  output logic [4:0]  op_spec_out,
  output logic [4:0]  rd_ind_out,
  output logic [31:0] rd_dat_out,
  output logic [31:0] mem_dat_out,
  output logic        misalign_out
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [29:0] waddr_q, waddr_d;
  logic [1:0]  off_q, off_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdat_q, wdat_d;
  logic [3:0]  op_type_q, op_type_d;
  logic [4:0]  op_spec_q, op_spec_d;
  logic [4:0]  rd_ind_q, rd_ind_d;
  logic [31:0] rd_dat_q, rd_dat_d;
  logic [31:0] mem_dat_q, mem_dat_d;
  logic        out_valid_q, out_valid_d;
  logic        misalign_q, misalign_d;

  logic        is_mem, is_byte, is_half, is_word, misaligned, go;
  logic [3:0]  be_new;
  logic [31:0] wdat_new, shifted, load_dat;

  // Incoming op decode
  always_comb begin
    is_mem     = (op_type == 4'd1) && (op_spec <= 5'd7);
    is_byte    = op_spec[2:0] inside {3'd0, 3'd3, 3'd5};
    is_half    = op_spec[2:0] inside {3'd1, 3'd4, 3'd6};
    is_word    = op_spec[2:0] inside {3'd2, 3'd7};
    misaligned = is_mem && ((is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00)));
    go         = in_valid && is_mem && !misaligned;
    if (is_byte) begin
      be_new   = 4'b0001 << addr[1:0];
      wdat_new = {4{st_dat[7:0]}};
    end else if (is_half) begin
      be_new   = 4'b0011 << addr[1:0];
      wdat_new = {2{st_dat[15:0]}};
    end else begin
      be_new   = 4'b1111;
      wdat_new = st_dat;
    end
  end

  // Load data right-justified from the captured offset, then trimmed to access width
  always_comb begin
    shifted = resp_rdat >> {off_q, 3'b000};
    if (op_spec_q[2:0] inside {3'd0, 3'd3})
      load_dat = {24'd0, shifted[7:0]};
    else if (op_spec_q[2:0] inside {3'd1, 3'd4})
      load_dat = {16'd0, shifted[15:0]};
    else
      load_dat = shifted;
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    waddr_d     = waddr_q;
    off_d       = off_q;
    be_d        = be_q;
    wdat_d      = wdat_q;
    op_type_d   = op_type_q;
    op_spec_d   = op_spec_q;
    rd_ind_d    = rd_ind_q;
    rd_dat_d    = rd_dat_q;
    mem_dat_d   = mem_dat_q;
    misalign_d  = misalign_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        mem_dat_d  = '0;
        misalign_d = 1'b0;
        if (in_valid) begin
          op_type_d  = op_type;
          op_spec_d  = op_spec;
          rd_ind_d   = rd_ind;
          rd_dat_d   = rd_dat;
          misalign_d = misaligned;
          if (go) begin
            state_d = REQ;
            we_d    = (op_spec[2:0] >= 3'd5);
            waddr_d = addr[31:2];
            off_d   = addr[1:0];
            be_d    = be_new;
            wdat_d  = wdat_new;
          end else begin
            out_valid_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (req_ready) begin
          state_d     = we_q ? DONE : WAIT;
          out_valid_d = we_q;
        end
      end
      WAIT: begin
        if (resp_valid) begin
          mem_dat_d   = load_dat;
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      off_q       <= '0;
      be_q        <= '0;
      wdat_q      <= '0;
      op_type_q   <= '0;
      op_spec_q   <= '0;
      rd_ind_q    <= '0;
      rd_dat_q    <= '0;
      mem_dat_q   <= '0;
      out_valid_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      off_q       <= off_d;
      be_q        <= be_d;
      wdat_q      <= wdat_d;
      op_type_q   <= op_type_d;
      op_spec_q   <= op_spec_d;
      rd_ind_q    <= rd_ind_d;
      rd_dat_q    <= rd_dat_d;
      mem_dat_q   <= mem_dat_d;
      out_valid_q <= out_valid_d;
      misalign_q  <= misalign_d;
    end
  end

  assign stall        = (state_q == REQ) || (state_q == WAIT) || ((state_q == IDLE) && go);
  assign req_valid    = (state_q == REQ);
  assign req_we       = we_q;
  assign req_addr     = {waddr_q, 2'b00};
  assign req_be       = be_q;
  assign req_wdat     = wdat_q;
  assign out_valid    = out_valid_q;
  assign op_type_out  = op_type_q;
  assign op_spec_out  = op_spec_q;
  assign rd_ind_out   = rd_ind_q;
  assign rd_dat_out   = rd_dat_q;
  assign mem_dat_out  = mem_dat_q;
  assign misalign_out = misalign_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed testbench for mem_access: loads, stores, misalignment, pass-through, reset.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  op_type = '0;
  logic [4:0]  op_spec = '0;
  logic [31:0] addr = '0;
  logic [31:0] st_dat = '0;
  logic [4:0]  rd_ind = '0;
  logic [31:0] rd_dat = '0;
  logic        stall;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdat;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_rdat = '0;
  logic        out_valid;
  logic [3:0]  op_type_out;
  logic [4:0]  op_spec_out;
  logic [4:0]  rd_ind_out;
  logic [31:0] rd_dat_out;
  logic [31:0] mem_dat_out;
  logic        misalign_out;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  mem_access dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op_type(op_type), .op_spec(op_spec),
    .addr(addr), .st_dat(st_dat), .rd_ind(rd_ind), .rd_dat(rd_dat), .stall(stall),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_be(req_be), .req_wdat(req_wdat), .resp_valid(resp_valid), .resp_rdat(resp_rdat),
    .out_valid(out_valid), .op_type_out(op_type_out), .op_spec_out(op_spec_out),
    .rd_ind_out(rd_ind_out), .rd_dat_out(rd_dat_out), .mem_dat_out(mem_dat_out),
    .misalign_out(misalign_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one aligned mem op at a negedge and follows it to completion.
  task automatic run_mem(input string tag, input logic [4:0] spec, input logic [31:0] a,
                         input logic [31:0] sd, input int unsigned wait_n,
                         input logic [31:0] rdat, input logic [3:0] ebe,
                         input logic [31:0] ewdat, input logic [31:0] emem);
    logic st;
    st = (spec >= 5'd5);
    @(negedge clk);
    in_valid = 1'b1; op_type = 4'd1; op_spec = spec; addr = a; st_dat = sd;
    rd_ind = 5'd3; rd_dat = a ^ 32'hFFFF0000;
    #1 chk({tag, "_stall_T"}, 32'(stall), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; op_type = '0; op_spec = '0; addr = '0; st_dat = '0;
    for (int unsigned i = 0; i <= wait_n; i++) begin
      chk({tag, "_req_valid"}, 32'(req_valid), 32'd1);
      chk({tag, "_req_addr"}, req_addr, {a[31:2], 2'b00});
      chk({tag, "_req_be"}, 32'(req_be), 32'(ebe));
      chk({tag, "_req_we"}, 32'(req_we), 32'(st));
      chk({tag, "_stall_req"}, 32'(stall), 32'd1);
      if (st) chk({tag, "_req_wdat"}, req_wdat, ewdat);
      req_ready = (i == wait_n);
      @(negedge clk);
    end
    req_ready = 1'b0;
    if (!st) begin
      chk({tag, "_req_valid_wait"}, 32'(req_valid), 32'd0);
      chk({tag, "_stall_wait"}, 32'(stall), 32'd1);
      resp_valid = 1'b1; resp_rdat = rdat;
      @(negedge clk);
      resp_valid = 1'b0; resp_rdat = '0;
    end
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_mem_dat"}, mem_dat_out, emem);
    chk({tag, "_stall_done"}, 32'(stall), 32'd0);
    chk({tag, "_rd_dat"}, rd_dat_out, a ^ 32'hFFFF0000);
    chk({tag, "_rd_ind"}, 32'(rd_ind_out), 32'd3);
    chk({tag, "_op_spec"}, 32'(op_spec_out), 32'(spec));
    chk({tag, "_misalign"}, 32'(misalign_out), 32'd0);
    @(negedge clk);
    chk({tag, "_out_valid_end"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #2;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mem_dat", mem_dat_out, 32'd0);
    chk("rst_req_addr", req_addr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_mem("lw100", 5'd2, 32'h100, 32'h0, 0, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF);
    run_mem("lb203", 5'd0, 32'h203, 32'h0, 0, 32'h80FF1234, 4'b1000, 32'h0, 32'h00000080);
    run_mem("lhu202", 5'd4, 32'h202, 32'h0, 0, 32'hABCD0000, 4'b1100, 32'h0, 32'h0000ABCD);
    run_mem("lh002", 5'd1, 32'h002, 32'h0, 1, 32'h12345678, 4'b1100, 32'h0, 32'h00001234);
    run_mem("lbu001", 5'd3, 32'h001, 32'h0, 0, 32'h12345678, 4'b0010, 32'h0, 32'h00000056);
    run_mem("sh42", 5'd6, 32'h42, 32'h1234BEEF, 3, 32'h0, 4'b1100, 32'hBEEFBEEF, 32'h0);
    run_mem("sb101", 5'd5, 32'h101, 32'h000000A5, 0, 32'h0, 4'b0010, 32'hA5A5A5A5, 32'h0);
    run_mem("sw200", 5'd7, 32'h200, 32'hCAFEF00D, 1, 32'h0, 4'b1111, 32'hCAFEF00D, 32'h0);

    // Misaligned lw
    @(negedge clk);
    in_valid = 1'b1; op_type = 4'd1; op_spec = 5'd2; addr = 32'h102; rd_ind = 5'd4; rd_dat = 32'h77;
    #1 chk("mis_stall", 32'(stall), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mis_req_valid", 32'(req_valid), 32'd0);
    chk("mis_out_valid", 32'(out_valid), 32'd1);
    chk("mis_flag", 32'(misalign_out), 32'd1);
    chk("mis_mem_dat", mem_dat_out, 32'd0);
    chk("mis_stall2", 32'(stall), 32'd0);
    @(negedge clk);
    chk("mis_out_valid_end", 32'(out_valid), 32'd0);
    chk("mis_req_valid_end", 32'(req_valid), 32'd0);

    // op_type 1 with op_spec 9 is not a memory op; odd address must not flag
    in_valid = 1'b1; op_type = 4'd1; op_spec = 5'd9; addr = 32'h101; rd_dat = 32'h99;
    #1 chk("spec9_stall", 32'(stall), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("spec9_out_valid", 32'(out_valid), 32'd1);
    chk("spec9_misalign", 32'(misalign_out), 32'd0);
    chk("spec9_req_valid", 32'(req_valid), 32'd0);
    chk("spec9_rd_dat", rd_dat_out, 32'h99);

    // ALU op followed back-to-back by lw, then reset during WAIT
    @(negedge clk);
    in_valid = 1'b1; op_type = 4'd0; op_spec = 5'd2; addr = 32'h300; rd_ind = 5'd7; rd_dat = 32'h1111;
    #1 chk("alu_stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("alu_out_valid", 32'(out_valid), 32'd1);
    chk("alu_rd_dat", rd_dat_out, 32'h1111);
    chk("alu_rd_ind", 32'(rd_ind_out), 32'd7);
    chk("alu_op_type", 32'(op_type_out), 32'd0);
    op_type = 4'd1; rd_ind = 5'd9; rd_dat = 32'h2222;
    #1 chk("b2b_stall", 32'(stall), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; op_type = '0;
    chk("b2b_req_valid", 32'(req_valid), 32'd1);
    chk("b2b_req_addr", req_addr, 32'h300);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    chk("b2b_wait_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_req_valid", 32'(req_valid), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_rd_dat", rd_dat_out, 32'd0);
    chk("arst_req_be", 32'(req_be), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    resp_valid = 1'b1; resp_rdat = 32'hFFFFFFFF;
    @(negedge clk);
    resp_valid = 1'b0;
    chk("late_out_valid", 32'(out_valid), 32'd0);
    chk("late_mem_dat", mem_dat_out, 32'd0);
    chk("late_stall", 32'(stall), 32'd0);
    chk("late_req_valid", 32'(req_valid), 32'd0);
    @(negedge clk);
    chk("late_out_valid2", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
